// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Main control FSM of the multicycle RV32I core (fetch/decode/
//            execute/memory/writeback sequencing over shared datapaths).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pcupdate,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [2:0] immsrc,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_EXECI    = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_JUMP     = 4'd10;
    localparam logic [3:0] c_JALR     = 4'd11;
    localparam logic [3:0] c_LUI      = 4'd12;
    localparam logic [3:0] c_AUIPC    = 4'd13;
    localparam logic [3:0] c_ERROR    = 4'd14;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_taken;
    logic       w_pcupdate;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = ~lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = ~ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = c_ERROR;
        case (r_state)
            c_FETCH:    w_next = mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next = c_MEMADR;
                    c_OP_RTYPE:            w_next = c_EXECR;
                    c_OP_ITYPE:            w_next = c_EXECI;
                    // funct3 010/011 are not defined branch conditions
                    c_OP_BRANCH:           w_next = (funct3[2:1] == 2'b01) ? c_ERROR : c_BRANCH;
                    c_OP_JAL:              w_next = c_JUMP;
                    c_OP_JALR:             w_next = c_JALR;
                    c_OP_LUI:              w_next = c_LUI;
                    c_OP_AUIPC:            w_next = c_AUIPC;
                    default:               w_next = c_ERROR;
                endcase
            end
            c_MEMADR:   w_next = (op == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
            c_MEMREAD:  w_next = mem_ready ? c_MEMWB : c_MEMREAD;
            c_MEMWB:    w_next = c_FETCH;
            c_MEMWRITE: w_next = mem_ready ? c_FETCH : c_MEMWRITE;
            c_EXECR:    w_next = c_ALUWB;
            c_EXECI:    w_next = c_ALUWB;
            c_ALUWB:    w_next = c_FETCH;
            c_BRANCH:   w_next = c_FETCH;
            c_JUMP:     w_next = c_ALUWB;
            c_JALR:     w_next = c_JUMP;
            c_LUI:      w_next = c_FETCH;
            c_AUIPC:    w_next = c_ALUWB;
            c_ERROR:    w_next = c_ERROR;
            default:    w_next = c_ERROR;
        endcase
    end

    always_comb begin
        w_pcupdate = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        adrsrc     = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        immsrc     = 3'b000;
        illegal    = 1'b0;
        case (r_state)
            c_FETCH: begin
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
                w_irwrite  = mem_ready;
                w_pcupdate = mem_ready;
            end
            c_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = (op == c_OP_JAL) ? 3'b011 : 3'b010;
            end
            c_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = (op == c_OP_LOAD) ? 3'b000 : 3'b001;
            end
            c_MEMREAD: begin
                adrsrc = 1'b1;
            end
            c_MEMWB: begin
                resultsrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            c_MEMWRITE: begin
                adrsrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            c_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            c_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                immsrc  = (funct3[1:0] == 2'b01) ? 3'b101 : 3'b000;
            end
            c_ALUWB: begin
                w_regwrite = 1'b1;
            end
            c_BRANCH: begin
                alusrca    = 2'b10;
                aluop      = 2'b01;
                w_pcupdate = w_taken;
            end
            c_JUMP: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                w_pcupdate = 1'b1;
            end
            c_JALR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            c_LUI: begin
                immsrc     = 3'b100;
                resultsrc  = 2'b11;
                w_regwrite = 1'b1;
            end
            c_AUIPC: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = 3'b100;
            end
            c_ERROR: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    // Strobes are masked while reset is held so FETCH's mem_ready path stays quiet
    assign pcupdate = w_pcupdate & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Directed scoreboard bench for the multicycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcupdate, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop;
    logic [2:0] immsrc;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    logic [20:0] expq[$];
    string       tagq[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .pcupdate(pcupdate),
        .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .immsrc(immsrc),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Packed order: state, pcupdate, adrsrc, memwrite, irwrite, regwrite,
    // resultsrc, alusrca, alusrcb, aluop, immsrc, illegal
    function automatic logic [20:0] e(input logic [3:0] st, input logic pcu, adr, mw, irw, rw,
                                      input logic [1:0] rs, sa, sb, ao,
                                      input logic [2:0] im, input logic ill);
        return {st, pcu, adr, mw, irw, rw, rs, sa, sb, ao, im, ill};
    endfunction

    function automatic logic [20:0] x_fetch(input logic mr);
        return e(4'd0, mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [20:0] x_decode(input logic [2:0] im);
        return e(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, 0);
    endfunction

    task automatic step(input logic mr, input logic [20:0] ex, input string tag);
        logic [20:0] got, want;
        string t;
        mem_ready = mr;
        expq.push_back(ex);
        tagq.push_back(tag);
        @(negedge clk);
        got  = {state, pcupdate, adrsrc, memwrite, irwrite, regwrite,
                resultsrc, alusrca, alusrcb, aluop, immsrc, illegal};
        want = expq.pop_front();
        t    = tagq.pop_front();
        total++;
        assert (got === want) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", t, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with mem_ready high: FETCH but no strobes
        step(1, e(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), "reset_fetch_a");
        step(1, e(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), "reset_fetch_b");
        reset = 1'b0;

        // lw with one fetch wait and two MEMREAD waits
        op = 7'b0000011; funct3 = 3'b010;
        step(0, x_fetch(0), "lw_fetch_wait");
        step(1, x_fetch(1), "lw_fetch");
        step(0, x_decode(3'b010), "lw_decode");
        step(0, e(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), "lw_memadr");
        step(0, e(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "lw_memread_w1");
        step(0, e(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "lw_memread_w2");
        step(1, e(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "lw_memread");
        step(1, e(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0), "lw_memwb");

        // sw with one wait cycle
        op = 7'b0100011;
        step(1, x_fetch(1), "sw_fetch");
        step(1, x_decode(3'b010), "sw_decode");
        step(1, e(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0), "sw_memadr");
        step(0, e(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "sw_memwrite_w");
        step(1, e(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "sw_memwrite");

        // bne taken, bgeu not taken, beq taken
        op = 7'b1100011; funct3 = 3'b001; zero = 1'b0;
        step(1, x_fetch(1), "bne_fetch");
        step(0, x_decode(3'b010), "bne_decode");
        step(0, e(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000, 0), "bne_branch");
        funct3 = 3'b111; ltu = 1'b1;
        step(1, x_fetch(1), "bgeu_fetch");
        step(1, x_decode(3'b010), "bgeu_decode");
        step(1, e(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000, 0), "bgeu_branch");
        funct3 = 3'b000; zero = 1'b1; ltu = 1'b0;
        step(1, x_fetch(1), "beq_fetch");
        step(1, x_decode(3'b010), "beq_decode");
        step(1, e(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b000, 0), "beq_branch");
        zero = 1'b0;

        // R-type add
        op = 7'b0110011;
        step(1, x_fetch(1), "add_fetch");
        step(1, x_decode(3'b010), "add_decode");
        step(1, e(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0), "add_execr");
        step(1, e(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "add_aluwb");

        // srai then addi
        op = 7'b0010011; funct3 = 3'b101;
        step(1, x_fetch(1), "srai_fetch");
        step(1, x_decode(3'b010), "srai_decode");
        step(1, e(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b101, 0), "srai_execi");
        step(1, e(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "srai_aluwb");
        funct3 = 3'b000;
        step(1, x_fetch(1), "addi_fetch");
        step(1, x_decode(3'b010), "addi_decode");
        step(1, e(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 0), "addi_execi");
        step(1, e(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "addi_aluwb");

        // jal
        op = 7'b1101111;
        step(1, x_fetch(1), "jal_fetch");
        step(1, x_decode(3'b011), "jal_decode");
        step(1, e(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0), "jal_jump");
        step(1, e(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "jal_aluwb");

        // jalr
        op = 7'b1100111;
        step(1, x_fetch(1), "jalr_fetch");
        step(1, x_decode(3'b010), "jalr_decode");
        step(1, e(4'd11, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), "jalr_jalr");
        step(1, e(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0), "jalr_jump");
        step(1, e(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "jalr_aluwb");

        // lui
        op = 7'b0110111;
        step(1, x_fetch(1), "lui_fetch");
        step(1, x_decode(3'b010), "lui_decode");
        step(1, e(4'd12, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100, 0), "lui_lui");

        // auipc
        op = 7'b0010111;
        step(1, x_fetch(1), "auipc_fetch");
        step(1, x_decode(3'b010), "auipc_decode");
        step(1, e(4'd13, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100, 0), "auipc_auipc");
        step(1, e(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "auipc_aluwb");

        // Asynchronous reset while a load waits in MEMREAD
        op = 7'b0000011; funct3 = 3'b010;
        step(1, x_fetch(1), "rst_lw_fetch");
        step(1, x_decode(3'b010), "rst_lw_decode");
        step(0, e(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), "rst_lw_memadr");
        step(0, e(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), "rst_lw_memread");
        reset = 1'b1;
        step(1, e(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), "rst_async");
        reset = 1'b0;
        step(1, x_fetch(1), "rst_release_fetch");

        // Illegal opcode: ERROR holds regardless of inputs
        op = 7'b0000000;
        step(1, x_decode(3'b010), "ill_decode");
        for (int i = 0; i < 20; i++) begin
            op     = 7'($urandom);
            funct3 = 3'($urandom);
            zero   = 1'($urandom);
            lt     = 1'($urandom);
            ltu    = 1'($urandom);
            step(1'($urandom), e(4'd14, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), "ill_hold");
        end
        reset = 1'b1;
        step(1, e(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), "ill_reset");
        reset = 1'b0;

        // Branch with reserved funct3 010
        op = 7'b1100011; funct3 = 3'b010; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        step(1, x_fetch(1), "bill_fetch");
        step(1, x_decode(3'b010), "bill_decode");
        step(1, e(4'd14, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), "bill_error");
        step(0, e(4'd14, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), "bill_hold");
        reset = 1'b1;
        step(0, e(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0), "bill_reset");
        reset = 1'b0;
        step(1, x_fetch(1), "final_fetch");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
